// File: rtl/arm_pkg.sv
// Shared ARM-subset pipeline definitions: widths, EXE commands and the
// ID->EXE stage bundle.
package arm_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 4;
    localparam int SHIFT_OP_W = 12;
    localparam int EXE_CMD_W  = 4;
    localparam int STATUS_W   = 4;
    localparam int IMM24_W    = 24;
    localparam int CNT_W      = 16;

    localparam logic [EXE_CMD_W-1:0] EXE_NOP = 4'b0000;
    localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;
    localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;
    // Compare/test and memory ops reuse the arithmetic encodings.
    localparam logic [EXE_CMD_W-1:0] EXE_CMP = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_TST = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_LDR = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_STR = 4'b0010;

    typedef struct packed {
        logic                  valid;
        logic [WORD_W-1:0]     pc;
        logic [WORD_W-1:0]     val_rn;
        logic [WORD_W-1:0]     val_rm;
        logic [SHIFT_OP_W-1:0] shift_operand;
        logic                  imm;
        logic [IMM24_W-1:0]    signed_imm24;
        logic [REG_ADDR_W-1:0] dest;
        logic [EXE_CMD_W-1:0]  exe_cmd;
        logic                  mem_r_en;
        logic                  mem_w_en;
        logic                  wb_en;
        logic                  b;
        logic                  s;
        logic [STATUS_W-1:0]   status;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic                  mem_mode;
    } id_exe_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Cleared asynchronously by rst_n.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_full;

    assign w_full = &r_cnt;
    assign o_cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && !w_full) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID->EXE pipeline register with flush/freeze control and
// saturating stall/flush event counters.
module id_exe_reg
    import arm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [WORD_W-1:0]     id_pc,
    input  logic [WORD_W-1:0]     id_val_rn,
    input  logic [WORD_W-1:0]     id_val_rm,
    input  logic [SHIFT_OP_W-1:0] id_shift_operand,
    input  logic                  id_imm,
    input  logic [IMM24_W-1:0]    id_signed_imm24,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [EXE_CMD_W-1:0]  id_exe_cmd,
    input  logic                  id_mem_r_en,
    input  logic                  id_mem_w_en,
    input  logic                  id_wb_en,
    input  logic                  id_b,
    input  logic                  id_s,
    input  logic [STATUS_W-1:0]   id_status,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    output logic                  exe_valid,
    output logic [WORD_W-1:0]     exe_pc,
    output logic [WORD_W-1:0]     exe_val_rn,
    output logic [WORD_W-1:0]     exe_val_rm,
    output logic [SHIFT_OP_W-1:0] exe_shift_operand,
    output logic                  exe_imm,
    output logic [IMM24_W-1:0]    exe_signed_imm24,
    output logic [REG_ADDR_W-1:0] exe_dest,
    output logic [EXE_CMD_W-1:0]  exe_exe_cmd,
    output logic                  exe_mem_r_en,
    output logic                  exe_mem_w_en,
    output logic                  exe_wb_en,
    output logic                  exe_b,
    output logic                  exe_s,
    output logic [STATUS_W-1:0]   exe_status,
    output logic [REG_ADDR_W-1:0] exe_src1,
    output logic [REG_ADDR_W-1:0] exe_src2,
    output logic                  exe_mem_mode,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    id_exe_t r_stage;
    id_exe_t w_load;
    id_exe_t w_next;
    logic    w_stall_inc;

    always_comb begin
        w_load               = '0;
        w_load.valid         = id_valid;
        w_load.pc            = id_pc;
        w_load.val_rn        = id_val_rn;
        w_load.val_rm        = id_val_rm;
        w_load.shift_operand = id_shift_operand;
        w_load.imm           = id_imm;
        w_load.signed_imm24  = id_signed_imm24;
        w_load.dest          = id_dest;
        w_load.exe_cmd       = id_exe_cmd;
        w_load.status        = id_status;
        w_load.src1          = id_src1;
        w_load.src2          = id_src2;
        // A bubble from ID must not carry any side-effecting enable.
        w_load.mem_r_en      = id_mem_r_en & id_valid;
        w_load.mem_w_en      = id_mem_w_en & id_valid;
        w_load.wb_en         = id_wb_en & id_valid;
        w_load.b             = id_b & id_valid;
        w_load.s             = id_s & id_valid;
        w_load.mem_mode      = (id_mem_r_en | id_mem_w_en) & id_valid;
    end

    always_comb begin
        w_next = w_load;
        if (flush) begin
            w_next = '0;
        end else if (freeze) begin
            w_next = r_stage;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_next;
        end
    end

    assign w_stall_inc = freeze & ~flush;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (flush),
        .o_cnt (flush_cnt)
    );

    assign exe_valid         = r_stage.valid;
    assign exe_pc            = r_stage.pc;
    assign exe_val_rn        = r_stage.val_rn;
    assign exe_val_rm        = r_stage.val_rm;
    assign exe_shift_operand = r_stage.shift_operand;
    assign exe_imm           = r_stage.imm;
    assign exe_signed_imm24  = r_stage.signed_imm24;
    assign exe_dest          = r_stage.dest;
    assign exe_exe_cmd       = r_stage.exe_cmd;
    assign exe_mem_r_en      = r_stage.mem_r_en;
    assign exe_mem_w_en      = r_stage.mem_w_en;
    assign exe_wb_en         = r_stage.wb_en;
    assign exe_b             = r_stage.b;
    assign exe_s             = r_stage.s;
    assign exe_status        = r_stage.status;
    assign exe_src1          = r_stage.src1;
    assign exe_src2          = r_stage.src2;
    assign exe_mem_mode      = r_stage.mem_mode;

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: directed scenarios plus random traffic
// against a field-level reference model.
module tb_id_exe_reg;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_val_rn;
    logic [31:0] id_val_rm;
    logic [11:0] id_shift_operand;
    logic        id_imm;
    logic [23:0] id_signed_imm24;
    logic [3:0]  id_dest;
    logic [3:0]  id_exe_cmd;
    logic        id_mem_r_en;
    logic        id_mem_w_en;
    logic        id_wb_en;
    logic        id_b;
    logic        id_s;
    logic [3:0]  id_status;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        exe_valid;
    logic [31:0] exe_pc;
    logic [31:0] exe_val_rn;
    logic [31:0] exe_val_rm;
    logic [11:0] exe_shift_operand;
    logic        exe_imm;
    logic [23:0] exe_signed_imm24;
    logic [3:0]  exe_dest;
    logic [3:0]  exe_exe_cmd;
    logic        exe_mem_r_en;
    logic        exe_mem_w_en;
    logic        exe_wb_en;
    logic        exe_b;
    logic        exe_s;
    logic [3:0]  exe_status;
    logic [3:0]  exe_src1;
    logic [3:0]  exe_src2;
    logic        exe_mem_mode;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    id_exe_reg dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .freeze            (freeze),
        .flush             (flush),
        .id_valid          (id_valid),
        .id_pc             (id_pc),
        .id_val_rn         (id_val_rn),
        .id_val_rm         (id_val_rm),
        .id_shift_operand  (id_shift_operand),
        .id_imm            (id_imm),
        .id_signed_imm24   (id_signed_imm24),
        .id_dest           (id_dest),
        .id_exe_cmd        (id_exe_cmd),
        .id_mem_r_en       (id_mem_r_en),
        .id_mem_w_en       (id_mem_w_en),
        .id_wb_en          (id_wb_en),
        .id_b              (id_b),
        .id_s              (id_s),
        .id_status         (id_status),
        .id_src1           (id_src1),
        .id_src2           (id_src2),
        .exe_valid         (exe_valid),
        .exe_pc            (exe_pc),
        .exe_val_rn        (exe_val_rn),
        .exe_val_rm        (exe_val_rm),
        .exe_shift_operand (exe_shift_operand),
        .exe_imm           (exe_imm),
        .exe_signed_imm24  (exe_signed_imm24),
        .exe_dest          (exe_dest),
        .exe_exe_cmd       (exe_exe_cmd),
        .exe_mem_r_en      (exe_mem_r_en),
        .exe_mem_w_en      (exe_mem_w_en),
        .exe_wb_en         (exe_wb_en),
        .exe_b             (exe_b),
        .exe_s             (exe_s),
        .exe_status        (exe_status),
        .exe_src1          (exe_src1),
        .exe_src2          (exe_src2),
        .exe_mem_mode      (exe_mem_mode),
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: one word per output field, in a fixed order.
    localparam int NF = 18;
    logic [31:0] m_f [NF];
    int          m_stall;
    int          m_flush;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NF; i++) m_f[i] = '0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Order: valid pc rn rm shop imm simm24 dest cmd mr mw wb b s
    // status src1 src2 mem_mode
    task automatic model_edge();
        bit v;
        if (flush) begin
            for (int i = 0; i < NF; i++) m_f[i] = '0;
            if (m_flush < 65535) m_flush++;
        end else if (freeze) begin
            if (m_stall < 65535) m_stall++;
        end else begin
            v = id_valid;
            m_f[0]  = 32'(id_valid);
            m_f[1]  = id_pc;
            m_f[2]  = id_val_rn;
            m_f[3]  = id_val_rm;
            m_f[4]  = 32'(id_shift_operand);
            m_f[5]  = 32'(id_imm);
            m_f[6]  = 32'(id_signed_imm24);
            m_f[7]  = 32'(id_dest);
            m_f[8]  = 32'(id_exe_cmd);
            m_f[9]  = v ? 32'(id_mem_r_en) : 32'd0;
            m_f[10] = v ? 32'(id_mem_w_en) : 32'd0;
            m_f[11] = v ? 32'(id_wb_en) : 32'd0;
            m_f[12] = v ? 32'(id_b) : 32'd0;
            m_f[13] = v ? 32'(id_s) : 32'd0;
            m_f[14] = 32'(id_status);
            m_f[15] = 32'(id_src1);
            m_f[16] = 32'(id_src2);
            m_f[17] = (v && (id_mem_r_en || id_mem_w_en)) ? 32'd1 : 32'd0;
        end
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, ".valid"},  32'(exe_valid),         m_f[0]);
        chk({pfx, ".pc"},     exe_pc,                 m_f[1]);
        chk({pfx, ".rn"},     exe_val_rn,             m_f[2]);
        chk({pfx, ".rm"},     exe_val_rm,             m_f[3]);
        chk({pfx, ".shop"},   32'(exe_shift_operand), m_f[4]);
        chk({pfx, ".imm"},    32'(exe_imm),           m_f[5]);
        chk({pfx, ".simm"},   32'(exe_signed_imm24),  m_f[6]);
        chk({pfx, ".dest"},   32'(exe_dest),          m_f[7]);
        chk({pfx, ".cmd"},    32'(exe_exe_cmd),       m_f[8]);
        chk({pfx, ".mr"},     32'(exe_mem_r_en),      m_f[9]);
        chk({pfx, ".mw"},     32'(exe_mem_w_en),      m_f[10]);
        chk({pfx, ".wb"},     32'(exe_wb_en),         m_f[11]);
        chk({pfx, ".b"},      32'(exe_b),             m_f[12]);
        chk({pfx, ".s"},      32'(exe_s),             m_f[13]);
        chk({pfx, ".status"}, 32'(exe_status),        m_f[14]);
        chk({pfx, ".src1"},   32'(exe_src1),          m_f[15]);
        chk({pfx, ".src2"},   32'(exe_src2),          m_f[16]);
        chk({pfx, ".mmode"},  32'(exe_mem_mode),      m_f[17]);
        chk({pfx, ".stall"},  32'(stall_cnt),         32'(m_stall));
        chk({pfx, ".flush"},  32'(flush_cnt),         32'(m_flush));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        freeze = 0; flush = 0; id_valid = 0;
        id_pc = '0; id_val_rn = '0; id_val_rm = '0;
        id_shift_operand = '0; id_imm = 0; id_signed_imm24 = '0;
        id_dest = '0; id_exe_cmd = '0; id_mem_r_en = 0;
        id_mem_w_en = 0; id_wb_en = 0; id_b = 0; id_s = 0;
        id_status = '0; id_src1 = '0; id_src2 = '0;
    endtask

    task automatic rand_fields();
        id_valid         = ($urandom_range(0, 3) != 0);
        id_pc            = $urandom;
        id_val_rn        = $urandom;
        id_val_rm        = $urandom;
        id_shift_operand = 12'($urandom);
        id_imm           = 1'($urandom);
        id_signed_imm24  = 24'($urandom);
        id_dest          = 4'($urandom);
        id_exe_cmd       = 4'($urandom);
        id_mem_r_en      = 1'($urandom);
        id_mem_w_en      = 1'($urandom);
        id_wb_en         = 1'($urandom);
        id_b             = 1'($urandom);
        id_s             = 1'($urandom);
        id_status        = 4'($urandom);
        id_src1          = 4'($urandom);
        id_src2          = 4'($urandom);
    endtask

    task automatic all_ones();
        id_valid = 1; id_pc = '1; id_val_rn = '1; id_val_rm = '1;
        id_shift_operand = '1; id_imm = 1; id_signed_imm24 = '1;
        id_dest = '1; id_exe_cmd = '1; id_mem_r_en = 1;
        id_mem_w_en = 1; id_wb_en = 1; id_b = 1; id_s = 1;
        id_status = '1; id_src1 = '1; id_src2 = '1;
    endtask

    // Pulse reset between clock edges (we sit at posedge+1 here).
    task automatic mid_reset(input string tag);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all(tag);
        #2 rst_n = 1;
    endtask

    initial begin
        clear_inputs();
        all_ones();
        rst_n = 0;
        model_reset();
        #3;
        check_all("por");
        #4 rst_n = 1;

        // Load all-ones, then async reset mid-cycle.
        step();
        check_all("ones");
        chk("ones.pc", exe_pc, 32'hFFFF_FFFF);
        mid_reset("rst");

        clear_inputs();
        id_valid = 1; id_pc = 32'h10; id_shift_operand = 12'h0A3;
        id_imm = 1; id_mem_r_en = 1;
        step();
        chk("ld.pc", exe_pc, 32'h10);
        chk("ld.shop", 32'(exe_shift_operand), 32'h0A3);
        chk("ld.mmode", 32'(exe_mem_mode), 32'd1);
        check_all("ld");

        id_dest = 4'd5;
        step();
        freeze = 1; id_dest = 4'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz.dest", 32'(exe_dest), 32'd5);
        end
        chk("frz.stall", 32'(stall_cnt), 32'd3);
        freeze = 0;
        step();
        chk("rel.dest", 32'(exe_dest), 32'd9);
        check_all("rel");

        freeze = 1; flush = 1; id_valid = 1; id_wb_en = 1;
        step();
        chk("ff.valid", 32'(exe_valid), 32'd0);
        chk("ff.wb", 32'(exe_wb_en), 32'd0);
        chk("ff.flush", 32'(flush_cnt), 32'd1);
        chk("ff.stall", 32'(stall_cnt), 32'd3);
        check_all("ff");

        freeze = 0; flush = 0;
        id_valid = 0; id_mem_w_en = 1; id_wb_en = 1;
        step();
        chk("bub.mw", 32'(exe_mem_w_en), 32'd0);
        chk("bub.wb", 32'(exe_wb_en), 32'd0);
        chk("bub.mmode", 32'(exe_mem_mode), 32'd0);
        check_all("bub");

        // Reset while an instruction is held by freeze.
        all_ones();
        step();
        freeze = 1;
        step();
        check_all("hold");
        mid_reset("rstfrz");
        freeze = 0;

        for (int i = 0; i < 600; i++) begin
            rand_fields();
            freeze = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 7) == 0);
            step();
            check_all("rnd");
        end

        @(negedge clk);
        mid_reset("rst2");
        clear_inputs();
        freeze = 1;
        for (int i = 0; i < 65540; i++) step();
        chk("sat.stall", 32'(stall_cnt), 32'hFFFF);
        check_all("sat");
        step();
        chk("sat.hold", 32'(stall_cnt), 32'hFFFF);
        freeze = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
